// File: rtl/decoder_pkg.sv
// Shared constants and decode helpers for the scanning one-hot decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // One output bit of onehot(idx): true when bit position pos is the selected one.
    // Evaluated per bit so it works for any output width.
    function automatic logic onehot(input int idx, input int pos);
        return (idx == pos);
    endfunction

    // Maps a logical "selected" bit onto the physical output level.
    function automatic logic apply_polarity(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick on the last count of every PRESCALE-cycle period while running.
module tick_gen #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = run && (count_q == CW'(PRESCALE - 1));

    // Next count: clear wins, otherwise count while running, hold when stopped.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered N-to-2^N decoder with a direct mode and a prescaled scanning mode.
// Output width is limited only by the int range used by the decode helper.
module decoder_scan_nx
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned PRESCALE   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           mode,
    input  logic [N-1:0]   sel,
    input  logic           load,
    output logic [2**N-1:0] y,
    output logic [N-1:0]   idx,
    output logic           wrap
);

    localparam int unsigned W = 2 ** N;

    logic [N-1:0] idx_q, idx_d;
    logic [W-1:0] y_q, y_d;
    logic         wrap_q, wrap_d;
    logic         tick;
    logic         scan_run;
    logic         scan_clr;

    // Prescaler only advances when scanning; it is cleared by a load or while in
    // direct mode, but never while disabled so the scan phase survives en = 0.
    assign scan_run = en & (mode == MODE_SCAN);
    assign scan_clr = en & (load | (mode == MODE_DIRECT));

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (scan_clr),
        .run   (scan_run),
        .tick  (tick)
    );

    // Index / wrap next-state with mode priority: direct, then load, then step.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (en) begin
            if (mode == MODE_DIRECT) begin
                idx_d = sel;
            end else if (load) begin
                idx_d = sel;
            end else if (tick) begin
                idx_d  = idx_q + N'(1);
                wrap_d = (idx_q == {N{1'b1}});
            end
        end
    end

    // Output decode of the next index so y and idx update on the same edge.
    always_comb begin
        y_d = '0;
        for (int i = 0; i < int'(W); i++) begin
            y_d[i] = apply_polarity(en && onehot(int'(idx_d), i), ACTIVE_LOW);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            y_q    <= {W{ACTIVE_LOW}};
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Bench for decoder_scan_nx: two instances (PRESCALE=4 active-high, PRESCALE=1 active-low)
// share one stimulus stream and are compared against a behavioural model each edge.
module tb_decoder_scan_nx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       load = 1'b0;

    logic [3:0] y_a, y_b;
    logic [1:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = dut_a, 1 = dut_b.
    int m_idx  [2];
    int m_cnt  [2];
    int m_wrap [2];
    int m_en   [2];
    int pre    [2] = '{4, 1};
    int al     [2] = '{0, 1};

    always #5 clk = ~clk;

    decoder_scan_nx #(.N(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk), .rst_n (rst_n), .en (en), .mode (mode), .sel (sel), .load (load),
        .y (y_a), .idx (idx_a), .wrap (wrap_a)
    );

    decoder_scan_nx #(.N(2), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .mode (mode), .sel (sel), .load (load),
        .y (y_b), .idx (idx_b), .wrap (wrap_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_y(input int c);
        int v;
        v = m_en[c] != 0 ? (1 << m_idx[c]) : 0;
        if (al[c] != 0) v = v ^ 4'hF;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_idx[c] = 0; m_cnt[c] = 0; m_wrap[c] = 0; m_en[c] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, applied to both configurations.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            m_en[c] = int'(en);
            m_wrap[c] = 0;
            if (!en) begin
                // idx and prescaler frozen
            end else if (!mode) begin
                m_idx[c] = int'(sel);
                m_cnt[c] = 0;
            end else if (load) begin
                m_idx[c] = int'(sel);
                m_cnt[c] = 0;
            end else if (m_cnt[c] == pre[c] - 1) begin
                m_wrap[c] = (m_idx[c] == 3) ? 1 : 0;
                m_idx[c]  = (m_idx[c] + 1) % 4;
                m_cnt[c]  = 0;
            end else begin
                m_cnt[c]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " a.y"},    int'(y_a),    exp_y(0));
        check({tag, " a.idx"},  int'(idx_a),  m_idx[0]);
        check({tag, " a.wrap"}, int'(wrap_a), m_wrap[0]);
        check({tag, " b.y"},    int'(y_b),    exp_y(1));
        check({tag, " b.idx"},  int'(idx_b),  m_idx[1]);
        check({tag, " b.wrap"}, int'(wrap_b), m_wrap[1]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges; checked while still asserted.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int yseq [5];
        model_reset();

        // 1. Reset
        do_reset();
        check("reset y_a const", int'(y_a), 4'h0);
        check("reset y_b const", int'(y_b), 4'hF);

        // 2. DIRECT decode
        en = 1'b1;
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step("direct");
            check("direct y_a", int'(y_a), 1 << s);
        end

        // 3. SCAN sweep from idx 0: wrap after 16 edges
        sel = 2'd0;
        step("direct0");
        mode = 1'b1;
        n = 0;
        do begin
            step("sweep");
            n++;
        end while (!wrap_a && n < 40);
        check("sweep length", n, 16);
        check("sweep idx", int'(idx_a), 0);

        // 4. load coincident with a step
        for (int k = 0; k < 3; k++) step("pre-load");
        load = 1'b1;
        sel = 2'd2;
        step("load");
        check("load idx", int'(idx_a), 2);
        check("load y", int'(y_a), 4'b0100);
        check("load wrap", int'(wrap_a), 0);
        load = 1'b0;
        n = 0;
        do begin
            step("after-load");
            n++;
        end while (idx_a == 2'd2 && n < 20);
        check("after-load period", n, 4);

        // 5. en=0 freeze at idx=1, prescaler=2
        load = 1'b1;
        sel = 2'd1;
        step("load1");
        load = 1'b0;
        step("cnt1");
        step("cnt2");
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("frozen");
            check("frozen y", int'(y_a), 0);
        end
        en = 1'b1;
        step("reenable");
        check("reenable y", int'(y_a), 4'b0010);
        step("reenable step");
        check("reenable step idx", int'(idx_a), 2);

        // 6. Active-low, PRESCALE=1 sweep
        do_reset();
        mode = 1'b0;
        sel = 2'd0;
        yseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        step("al direct");
        check("al y0", int'(y_b), yseq[0]);
        mode = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step("al scan");
            check("al y", int'(y_b), yseq[k]);
        end
        check("al wrap", int'(wrap_b), 1);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load = ($urandom_range(0, 11) == 0);
            sel  = 2'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
